// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver.
//
// Deserializes frames of 1 start bit, 8 data bits (LSB first) and 1 stop
// bit arriving on an asynchronous line. Each bit lasts CLK_PER_BIT clocks.
// Received bytes are offered to the consumer on a valid/ready interface.
// Framing errors and overruns are reported as one-cycle pulses.
//
// Parameters
//   CLK_PER_BIT   clocks per serial bit (>= 4, must match the transmitter)
// Ports
//   i_clk         clock
//   i_rst         synchronous, active-high reset
//   i_rx          serial line, asynchronous to i_clk, idles high
//   o_data        received byte, stable while o_data_valid is high
//   o_data_valid  byte available, held until accepted
//   i_data_rdy    consumer accepts; transfer on o_data_valid & i_data_rdy
//   o_frame_err   one-cycle pulse: stop bit sampled low, byte discarded
//   o_overrun     one-cycle pulse: finished byte dropped, output still full
module uart_rx #(
  parameter int CLK_PER_BIT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_rdy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CW   = $clog2(CLK_PER_BIT);
  localparam int HALF = (CLK_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic          rx_s1, rx_s2;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          deliver;
  logic          frame_err;

  // Two-flop synchronizer. Reset high so a reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
    end
  end

  // State and bit-timing registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  // Next-state logic. The start bit is re-checked half a bit in, which both
  // filters glitches and moves every later sample to the middle of its bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    deliver   = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s2) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          if (!rx_s2) begin
            state_n = DATA;
            cnt_n   = '0;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s2, shift[7:1]};
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s2) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err = 1'b1;
            state_n   = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BREAK: begin
        // A held-low line must go high before a new start is accepted.
        if (rx_s2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output register. A byte finished while the previous one is still
  // unaccepted is dropped; an accept on the same cycle frees the slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_frame_err <= frame_err;
      o_overrun   <= 1'b0;
      if (deliver) begin
        if (!o_data_valid || i_data_rdy) begin
          o_data       <= shift;
          o_data_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_data_valid && i_data_rdy) begin
        o_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx  = 1'b1;
  logic       i_data_rdy = 1'b1;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_frame_err;
  logic       o_overrun;

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_rdy   (i_data_rdy),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] sb[$];
  int   deliv = 0, ferr_cyc = 0, ovr_cyc = 0, vld_cyc = 0;
  int   last_rise = -1, last_start = 0;
  logic prev_vld = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard: compares every handshake against the queue.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_frame_err) ferr_cyc++;
      if (o_overrun)   ovr_cyc++;
      if (o_data_valid) vld_cyc++;
      if (o_data_valid && !prev_vld) last_rise = cyc;
      if (o_data_valid && i_data_rdy) begin
        deliv++;
        if (sb.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL sb_unexpected: got byte %02h, expected none", o_data);
        end else begin
          chk("sb_data", int'(o_data), int'(sb.pop_front()));
        end
      end
    end
    prev_vld = o_data_valid;
  end

  // Stimulus is always driven 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    last_start = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop_low_bits > 0) begin
      i_rx = 1'b0;
      repeat (stop_low_bits * CPB) @(posedge i_clk);
      #1;
    end
    drive_bit(1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         exp_deliv;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[6];
  int d0, f0, o0, v0;

  initial begin
    tbl[0] = '{8'hA5, 0,  1, 0};
    tbl[1] = '{8'h00, 0,  1, 0};
    tbl[2] = '{8'hFF, 0,  1, 0};
    tbl[3] = '{8'h3C, 20, 0, 1};
    tbl[4] = '{8'h81, 0,  1, 0};
    tbl[5] = '{8'h7E, 0,  1, 0};

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_data",  int'(o_data), 0);
    chk("rst_valid", int'(o_data_valid), 0);
    chk("rst_ferr",  int'(o_frame_err), 0);
    chk("rst_ovr",   int'(o_overrun), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle(2 * CPB);

    // Single frames from the table, rdy held high
    for (int k = 0; k < 6; k++) begin
      d0 = deliv; f0 = ferr_cyc; o0 = ovr_cyc; v0 = vld_cyc;
      last_rise = -1;
      if (tbl[k].exp_deliv != 0) sb.push_back(tbl[k].data);
      send_frame(tbl[k].data, tbl[k].stop_low);
      idle(3 * CPB);
      chk($sformatf("v%0d_deliv", k), deliv - d0, tbl[k].exp_deliv);
      chk($sformatf("v%0d_ferr", k), ferr_cyc - f0, tbl[k].exp_ferr);
      chk($sformatf("v%0d_ovr", k), ovr_cyc - o0, 0);
      chk($sformatf("v%0d_vldcyc", k), vld_cyc - v0, tbl[k].exp_deliv);
      if (tbl[k].exp_deliv != 0)
        chk($sformatf("v%0d_latency", k), last_rise - last_start, 40);
      else
        chk($sformatf("v%0d_norise", k), last_rise, -1);
    end

    // Back-to-back frames with zero idle between stop and start
    d0 = deliv; f0 = ferr_cyc; o0 = ovr_cyc; v0 = vld_cyc;
    sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'h55);
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    send_frame(8'h55, 0);
    idle(3 * CPB);
    chk("b2b_deliv",  deliv - d0, 3);
    chk("b2b_ferr",   ferr_cyc - f0, 0);
    chk("b2b_ovr",    ovr_cyc - o0, 0);
    chk("b2b_vldcyc", vld_cyc - v0, 3);

    // One-clock glitch on an idle line
    d0 = deliv; f0 = ferr_cyc; o0 = ovr_cyc;
    last_rise = -1;
    i_rx = 1'b0;
    @(posedge i_clk); #1;
    idle(4 * CPB);
    chk("glitch_deliv", deliv - d0, 0);
    chk("glitch_ferr",  ferr_cyc - f0, 0);
    chk("glitch_ovr",   ovr_cyc - o0, 0);
    chk("glitch_rise",  last_rise, -1);

    // Overrun: consumer stalled across two frames
    d0 = deliv; f0 = ferr_cyc; o0 = ovr_cyc;
    i_data_rdy = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    idle(2 * CPB);
    @(negedge i_clk);
    chk("ovr_pulse", ovr_cyc - o0, 1);
    chk("ovr_ferr",  ferr_cyc - f0, 0);
    chk("ovr_data",  int'(o_data), 'h11);
    chk("ovr_valid", int'(o_data_valid), 1);
    @(posedge i_clk); #1;
    i_data_rdy = 1'b1;
    @(posedge i_clk); #1;
    i_data_rdy = 1'b0;
    @(negedge i_clk);
    chk("ovr_clear", int'(o_data_valid), 0);
    chk("ovr_deliv", deliv - d0, 1);
    @(posedge i_clk); #1;
    i_data_rdy = 1'b1;

    // Reset during data bit 4 of 0x99, held until the frame has passed
    d0 = deliv; f0 = ferr_cyc; o0 = ovr_cyc;
    fork
      send_frame(8'h99, 0);
      begin
        repeat (5 * CPB + 2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
      end
    join
    @(negedge i_clk);
    chk("mrst_data",  int'(o_data), 0);
    chk("mrst_valid", int'(o_data_valid), 0);
    chk("mrst_ferr",  int'(o_frame_err), 0);
    chk("mrst_ovr",   int'(o_overrun), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle(2 * CPB);
    chk("mrst_nodeliv", deliv - d0, 0);
    sb.push_back(8'h42);
    send_frame(8'h42, 0);
    idle(3 * CPB);
    chk("mrst_deliv", deliv - d0, 1);
    chk("mrst_ferr2", ferr_cyc - f0, 0);
    chk("mrst_ovr2",  ovr_cyc - o0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
